// File: rtl/id_ex_elastic_reg_pkg.sv
// rtl/id_ex_elastic_reg_pkg.sv - shared widths, control bit indices, payload struct and state encoding
// for the ID/EX elastic stage.
package id_ex_pkg;

  localparam int DEF_XLEN    = 64;
  localparam int DEF_REG_AW  = 5;
  localparam int DEF_FUNCT_W = 4;
  localparam int DEF_ALUOP_W = 2;
  localparam int DEF_CNT_W   = 32;

  localparam int CTRL_W = DEF_ALUOP_W + 6;

  localparam int CTRL_MEM_TO_REG  = 0;
  localparam int CTRL_REG_WRITE   = 1;
  localparam int CTRL_BRANCH      = 2;
  localparam int CTRL_MEM_WRITE   = 3;
  localparam int CTRL_MEM_READ    = 4;
  localparam int CTRL_ALU_SRC     = 5;
  localparam int CTRL_ALU_OP_LSB  = 6;

  typedef struct packed {
    logic [DEF_XLEN-1:0]    pc;
    logic [DEF_XLEN-1:0]    rs1_data;
    logic [DEF_XLEN-1:0]    rs2_data;
    logic [DEF_XLEN-1:0]    imm;
    logic [DEF_FUNCT_W-1:0] funct;
    logic [DEF_REG_AW-1:0]  rd;
    logic [DEF_REG_AW-1:0]  rs1;
    logic [DEF_REG_AW-1:0]  rs2;
    logic [CTRL_W-1:0]      ctrl;
  } id_ex_payload_t;

  // Encoding doubles as {s_v, m_v}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

endpackage

// File: rtl/id_ex_elastic_reg_if.sv
// rtl/id_ex_elastic_reg_if.sv - decode-side and execute-side handshake bundle of the ID/EX stage;
// perf counter signals exist only with ID_EX_PERF_CNT_EN.
interface id_ex_elastic_reg_if
  import id_ex_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int FUNCT_W = DEF_FUNCT_W,
  parameter int ALUOP_W = DEF_ALUOP_W
`ifdef ID_EX_PERF_CNT_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
);
  localparam int CW = ALUOP_W + 6;

  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [FUNCT_W-1:0] in_funct;
  logic [REG_AW-1:0]  in_rd, in_rs1, in_rs2;
  logic [CW-1:0]      in_ctrl;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [FUNCT_W-1:0] out_funct;
  logic [REG_AW-1:0]  out_rd, out_rs1, out_rs2;
  logic [CW-1:0]      out_ctrl;

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0]   stall_cnt, bubble_cnt, flush_cnt;
`endif

  // Pipeline environment: decode source plus execute sink.
  modport master (
`ifdef ID_EX_PERF_CNT_EN
    input  stall_cnt, bubble_cnt, flush_cnt,
`endif
    output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm, in_funct,
    output in_rd, in_rs1, in_rs2, in_ctrl, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
    input  out_funct, out_rd, out_rs1, out_rs2, out_ctrl
  );

  // The elastic stage itself.
  modport slave (
`ifdef ID_EX_PERF_CNT_EN
    output stall_cnt, bubble_cnt, flush_cnt,
`endif
    input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm, in_funct,
    input  in_rd, in_rs1, in_rs2, in_ctrl, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
    output out_funct, out_rd, out_rs1, out_rs2, out_ctrl
  );

endinterface

// File: rtl/id_ex_payload_reg.sv
// rtl/id_ex_payload_reg.sv - width-generic enabled register, falling-edge clocked, async active-low
// clear; used for the main and skid entries.
module id_ex_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_elastic_reg.sv
// rtl/id_ex_elastic_reg.sv - elastic ID/EX stage with 2-entry skid buffer and synchronous flush;
// ID_EX_PERF_CNT_EN adds saturating stall/bubble/flush counters.
module id_ex_elastic_reg
  import id_ex_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int REG_AW  = DEF_REG_AW,
  parameter int FUNCT_W = DEF_FUNCT_W,
  parameter int ALUOP_W = DEF_ALUOP_W
`ifdef ID_EX_PERF_CNT_EN
  , parameter int CNT_W = DEF_CNT_W
`endif
) (
  input logic             clk,
  input logic             rst_n,
  input logic             flush,
  id_ex_elastic_reg_if.slave bus
);

  localparam int CW = ALUOP_W + 6;
  localparam int PW = 4 * XLEN + FUNCT_W + 3 * REG_AW + CW;

  state_t          state_q, state_d;
  logic            in_ready_q;
  logic            m_v, accept, consume;
  logic            m_en, s_en;
  logic [PW-1:0]   in_word, m_word, s_word, m_d;

  assign in_word = {bus.in_pc, bus.in_rs1_data, bus.in_rs2_data, bus.in_imm, bus.in_funct,
                    bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_ctrl};

  assign m_v     = (state_q != EMPTY);
  assign accept  = bus.in_valid & in_ready_q;
  assign consume = m_v & bus.out_ready;

  always_comb begin
    state_d = state_q;
    m_en    = 1'b0;
    s_en    = 1'b0;
    m_d     = in_word;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          m_en    = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          m_en = 1'b1;
        end else if (accept) begin
          s_en    = 1'b1;
          state_d = FULL;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          m_en    = 1'b1;
          m_d     = s_word;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over everything; a same-cycle consume has already transferred.
    if (flush) begin
      state_d = EMPTY;
      m_en    = 1'b0;
      s_en    = 1'b0;
    end
  end

  // in_ready is registered from the next state so the source never sees a combinational path.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  id_ex_payload_reg #(.W(PW)) u_m (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (m_en),
    .d     (m_d),
    .q     (m_word)
  );

  id_ex_payload_reg #(.W(PW)) u_s (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (s_en),
    .d     (in_word),
    .q     (s_word)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = m_v;
  assign {bus.out_pc, bus.out_rs1_data, bus.out_rs2_data, bus.out_imm, bus.out_funct,
          bus.out_rd, bus.out_rs1, bus.out_rs2} = m_word[PW-1:CW];
  assign bus.out_ctrl  = m_v ? m_word[CW-1:0] : '0;

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q, flush_cnt_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      if (bus.in_valid && !in_ready_q && !flush && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (!m_v && bus.out_ready && !(&bubble_cnt_q)) bubble_cnt_q <= bubble_cnt_q + 1'b1;
      if (flush && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// tb/tb_id_ex_elastic_reg.sv - scoreboard bench for id_ex_elastic_reg against a 2-deep FIFO model;
// counter checks compile in with ID_EX_PERF_CNT_EN.
module tb_id_ex_elastic_reg;
  import id_ex_pkg::*;

  localparam int PAYW = $bits(id_ex_payload_t);

  logic clk = 1'b1;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  id_ex_elastic_reg_if bus ();

  id_ex_elastic_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  id_ex_payload_t sb_q[$];

  task automatic chk(input string nm, input logic [PAYW-1:0] act, input logic [PAYW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic id_ex_payload_t rand_pay();
    id_ex_payload_t p;
    p.pc       = {$urandom, $urandom};
    p.rs1_data = {$urandom, $urandom};
    p.rs2_data = {$urandom, $urandom};
    p.imm      = {$urandom, $urandom};
    p.funct    = 4'($urandom);
    p.rd       = 5'($urandom);
    p.rs1      = 5'($urandom);
    p.rs2      = 5'($urandom);
    p.ctrl     = 8'($urandom);
    return p;
  endfunction

  function automatic id_ex_payload_t in_pay();
    id_ex_payload_t p;
    p.pc = bus.in_pc;   p.rs1_data = bus.in_rs1_data; p.rs2_data = bus.in_rs2_data;
    p.imm = bus.in_imm; p.funct = bus.in_funct;       p.rd = bus.in_rd;
    p.rs1 = bus.in_rs1; p.rs2 = bus.in_rs2;           p.ctrl = bus.in_ctrl;
    return p;
  endfunction

  function automatic id_ex_payload_t out_pay();
    id_ex_payload_t p;
    p.pc = bus.out_pc;   p.rs1_data = bus.out_rs1_data; p.rs2_data = bus.out_rs2_data;
    p.imm = bus.out_imm; p.funct = bus.out_funct;       p.rd = bus.out_rd;
    p.rs1 = bus.out_rs1; p.rs2 = bus.out_rs2;           p.ctrl = bus.out_ctrl;
    return p;
  endfunction

  task automatic apply(input id_ex_payload_t p);
    bus.in_pc = p.pc;   bus.in_rs1_data = p.rs1_data; bus.in_rs2_data = p.rs2_data;
    bus.in_imm = p.imm; bus.in_funct = p.funct;       bus.in_rd = p.rd;
    bus.in_rs1 = p.rs1; bus.in_rs2 = p.rs2;           bus.in_ctrl = p.ctrl;
  endtask

  task automatic step(input logic v, input logic [63:0] pc, input logic [7:0] ctrl,
                      input logic [4:0] rd, input logic ordy, input logic fl);
    id_ex_payload_t p;
    p = rand_pay();
    p.pc = pc; p.ctrl = ctrl; p.rd = rd;
    @(negedge clk);
    #1;
    apply(p);
    bus.in_valid  = v;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  // Model: the stage is a FIFO of depth 2 whose head is always on out_*.
  always @(posedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      chk("out_valid", PAYW'(bus.out_valid), PAYW'(sb_q.size() > 0));
      chk("in_ready", PAYW'(bus.in_ready), PAYW'(sb_q.size() < 2));
      if (sb_q.size() > 0) chk("payload", out_pay(), sb_q[0]);
      else                 chk("bubble_ctrl", PAYW'(bus.out_ctrl), '0);
      if (bus.out_valid && bus.out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
      if (flush) sb_q.delete();
      else if (bus.in_valid && bus.in_ready) sb_q.push_back(in_pay());
    end
  end

  initial begin
    id_ex_payload_t p;
    rst_n = 1'b0;
    flush = 1'b0;
    apply('0);
    bus.in_valid  = 1'b1;
    bus.in_pc     = 64'h1000;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    chk("rst_out_valid", PAYW'(bus.out_valid), '0);
    chk("rst_out_ctrl", PAYW'(bus.out_ctrl), '0);
    chk("rst_in_ready", PAYW'(bus.in_ready), PAYW'(1));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    chk("no_capture", PAYW'(bus.out_valid), '0);

    // Streaming
    for (int i = 0; i < 4; i++) step(1'b1, 64'(i * 4), 8'($urandom), 5'($urandom), 1'b1, 1'b0);
    step(1'b0, 64'h0, 8'h0, 5'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 8'h0, 5'h0, 1'b1, 1'b0);

    // Backpressure
    step(1'b1, 64'h10, 8'h11, 5'd1, 1'b0, 1'b0);
    step(1'b1, 64'h14, 8'h22, 5'd2, 1'b0, 1'b0);
    step(1'b1, 64'h18, 8'h33, 5'd3, 1'b0, 1'b0);
    @(posedge clk);
    chk("bp_head_pc", PAYW'(bus.out_pc), PAYW'(64'h10));
    chk("bp_in_ready", PAYW'(bus.in_ready), '0);
    step(1'b1, 64'h18, 8'h33, 5'd3, 1'b1, 1'b0);
    repeat (4) step(1'b0, 64'h0, 8'h0, 5'h0, 1'b1, 1'b0);

    // Flush while FULL
    step(1'b1, 64'h30, 8'h44, 5'd4, 1'b0, 1'b0);
    step(1'b1, 64'h34, 8'h55, 5'd5, 1'b0, 1'b0);
    step(1'b1, 64'h20, 8'h66, 5'd6, 1'b0, 1'b1);
    step(1'b0, 64'h0, 8'h0, 5'h0, 1'b0, 1'b0);
    @(posedge clk);
    chk("flush_out_valid", PAYW'(bus.out_valid), '0);
    chk("flush_out_ctrl", PAYW'(bus.out_ctrl), '0);
    chk("flush_in_ready", PAYW'(bus.in_ready), PAYW'(1));

    // Bubble squash
    step(1'b1, 64'h40, 8'hFF, 5'd7, 1'b1, 1'b0);
    step(1'b0, 64'h0, 8'h0, 5'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 8'h0, 5'h0, 1'b1, 1'b0);
    @(posedge clk);
    chk("bubble_valid", PAYW'(bus.out_valid), '0);
    chk("bubble_ctrl_zero", PAYW'(bus.out_ctrl), '0);
    chk("bubble_rd_held", PAYW'(bus.out_rd), PAYW'(5'd7));

`ifdef ID_EX_PERF_CNT_EN
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 64'h50, 8'h1, 5'd1, 1'b0, 1'b0);
    step(1'b1, 64'h54, 8'h2, 5'd2, 1'b0, 1'b0);
    repeat (3) step(1'b1, 64'h58, 8'h3, 5'd3, 1'b0, 1'b0);
    step(1'b1, 64'h5C, 8'h4, 5'd4, 1'b0, 1'b1);
    step(1'b0, 64'h0, 8'h0, 5'h0, 1'b0, 1'b0);
    @(posedge clk);
    chk("stall_cnt", PAYW'(bus.stall_cnt), PAYW'(3));
    chk("flush_cnt", PAYW'(bus.flush_cnt), PAYW'(1));
    chk("bubble_cnt", PAYW'(bus.bubble_cnt), '0);
    force dut.stall_cnt_q = '1;
    @(negedge clk);
    #1;
    release dut.stall_cnt_q;
    step(1'b1, 64'h60, 8'h1, 5'd1, 1'b0, 1'b0);
    step(1'b1, 64'h64, 8'h2, 5'd2, 1'b0, 1'b0);
    repeat (2) step(1'b1, 64'h68, 8'h3, 5'd3, 1'b0, 1'b0);
    step(1'b0, 64'h0, 8'h0, 5'h0, 1'b0, 1'b0);
    @(posedge clk);
    chk("stall_cnt_sat", PAYW'(bus.stall_cnt), PAYW'(32'hFFFF_FFFF));
`endif

    // Random traffic with one asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      p = rand_pay();
      @(negedge clk);
      #1;
      apply(p);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 19) == 0);
      if (i == 200) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", PAYW'(bus.out_valid), '0);
        chk("async_rst_ready", PAYW'(bus.in_ready), PAYW'(1));
      end else begin
        rst_n = 1'b1;
      end
    end

    repeat (4) step(1'b0, 64'h0, 8'h0, 5'h0, 1'b1, 1'b0);
    @(posedge clk);
    chk("drained", PAYW'(bus.out_valid), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
